isa_program_sequencer: RTL and testbench

- Upstream stage of the compute-core wrapper: sits between the AXI host registers and the wrapper's control/data/status register interface.
- Accepts an instruction program as a valid/ready stream and resets the core. Writes each 44-bit instruction into the ISA command slots, pulses start, then waits for done with a timeout.
- Latches the final cycle count. When idle, passes host register values straight through, so DMA/BRAM host access is unchanged.

---
 rtl/isa_program_sequencer_pkg.sv | 58 +++++
 rtl/isa_program_sequencer_timeout_counter.sv | 30 +++
 rtl/isa_program_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_isa_program_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/isa_program_sequencer_pkg.sv
// Shared types and control/status word layout for the ISA program sequencer
// and its timeout counter.
package isa_program_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CRST,
        ST_LOAD,
        ST_START,
        ST_SETTLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR
    } seq_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_OVERFLOW = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_EMPTY    = 2'd3
    } err_code_e;

    // control_low_word fields
    localparam int ADDR_LSB    = 0;
    localparam int WEA_BIT     = 16;
    localparam int ISA_SEL_BIT = 17;
    localparam int GRANT_BIT   = 18;
    localparam int NEXP_LSB    = 27;
    localparam int BSEL_LSB    = 29;
    // control_high_word / status fields
    localparam int RST_BIT     = 0;
    localparam int START_BIT   = 1;
    localparam int DONE_BIT    = 0;
    localparam int CYC_LSB     = 2;

    function automatic logic [31:0] ctrl_low_word(input logic [3:0] addr,
                                                  input logic       wea,
                                                  input logic       isa_sel,
                                                  input logic       grant,
                                                  input logic [1:0] nexp,
                                                  input logic [2:0] bsel);
        logic [31:0] w;
        w                  = '0;
        w[ADDR_LSB +: 4]   = addr;
        w[WEA_BIT]         = wea;
        w[ISA_SEL_BIT]     = isa_sel;
        w[GRANT_BIT]       = grant;
        w[NEXP_LSB +: 2]   = nexp;
        w[BSEL_LSB +: 3]   = bsel;
        return w;
    endfunction

    // States in which the host owns the wrapper register words.
    function automatic logic is_host_state(input seq_state_e s);
        return s inside {ST_IDLE, ST_DONE, ST_ERR};
    endfunction

endpackage

// File: rtl/isa_program_sequencer_timeout_counter.sv
// Loadable, saturating down-counter shared by the reset, settle and
// done-wait phases of the sequencer.
module seq_timeout_counter #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/isa_program_sequencer.sv
// Loads an instruction stream into the wrapper's ISA slots, starts the core
// and waits for done; passes host register words through when idle.
module isa_program_sequencer
    import isa_program_sequencer_pkg::*;
#(
    parameter int MAX_INSTR      = 16,
    parameter int RST_CYCLES     = 4,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1 << 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [43:0] instr_data,
    input  logic        instr_last,
    input  logic [31:0] host_ctrl_low,
    input  logic [31:0] host_ctrl_high,
    input  logic [31:0] host_dina_low,
    input  logic [31:0] host_dina_high,
    input  logic [31:0] status,
    output logic [31:0] control_low_word,
    output logic [31:0] control_high_word,
    output logic [31:0] dina_ext_low_word,
    output logic [31:0] dina_ext_high_word,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [29:0] cycles
);

    localparam int SLOT_W = $clog2(MAX_INSTR);
    localparam int CNT_W  = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

    seq_state_e        state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              own_q, own_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    err_code_e         err_code_q, err_code_d;
    logic [29:0]       cycles_q, cycles_d;
    logic [31:0]       ctrl_low_q, ctrl_low_d;
    logic [31:0]       ctrl_high_q, ctrl_high_d;
    logic [31:0]       dina_low_q, dina_low_d;
    logic [31:0]       dina_high_q, dina_high_d;

    logic              cnt_load, cnt_en, cnt_zero;
    logic [CNT_W-1:0]  cnt_val;
    logic              xfer;
    logic              unused_status;

    assign unused_status = status[1];
    assign xfer = instr_valid && ready_q;

    seq_timeout_counter #(.W(CNT_W)) u_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .en_i       (cnt_en),
        .zero_o     (cnt_zero)
    );

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        own_d       = own_q;
        ready_d     = ready_q;
        done_d      = done_q;
        error_d     = error_q;
        err_code_d  = err_code_q;
        cycles_d    = cycles_q;
        ctrl_low_d  = ctrl_low_q;
        ctrl_high_d = ctrl_high_q;
        dina_low_d  = dina_low_q;
        dina_high_d = dina_high_q;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        cnt_val     = '0;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                own_d = 1'b0;
                if (go) begin
                    state_d               = ST_CRST;
                    own_d                 = 1'b1;
                    done_d                = 1'b0;
                    error_d               = 1'b0;
                    err_code_d            = ERR_NONE;
                    cycles_d              = '0;
                    ctrl_low_d            = '0;
                    ctrl_high_d           = '0;
                    ctrl_high_d[RST_BIT]  = 1'b1;
                    cnt_load              = 1'b1;
                    cnt_val               = CNT_W'(RST_CYCLES - 1);
                end
            end
            ST_CRST: begin
                if (cnt_zero) begin
                    state_d     = ST_LOAD;
                    slot_d      = '0;
                    ready_d     = 1'b1;
                    ctrl_high_d = '0;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_LOAD: begin
                ctrl_low_d[WEA_BIT] = 1'b0;
                if (xfer) begin
                    ctrl_low_d  = ctrl_low_word(4'(slot_q), 1'b1, 1'b1, 1'b0, 2'b00, 3'b000);
                    ctrl_high_d = '0;
                    dina_high_d = {20'd0, instr_data[43:32]};
                    dina_low_d  = instr_data[31:0];
                    slot_d      = slot_q + 1'b1;
                    if (instr_last) begin
                        state_d = ST_START;
                        ready_d = 1'b0;
                    end else if (slot_q == SLOT_W'(MAX_INSTR - 1)) begin
                        // own_q stays set for one ERR cycle so this last write lands.
                        state_d    = ST_ERR;
                        ready_d    = 1'b0;
                        error_d    = 1'b1;
                        err_code_d = ERR_OVERFLOW;
                    end
                end
            end
            ST_START: begin
                ctrl_low_d             = '0;
                ctrl_high_d            = '0;
                ctrl_high_d[START_BIT] = 1'b1;
                state_d                = ST_SETTLE;
                cnt_load               = 1'b1;
                cnt_val                = CNT_W'(SETTLE_CYCLES - 1);
            end
            ST_SETTLE: begin
                ctrl_high_d = '0;
                if (cnt_zero) begin
                    state_d  = ST_WAIT;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(TIMEOUT_CYCLES - 1);
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_WAIT: begin
                cnt_en = 1'b1;
                if (status[DONE_BIT]) begin
                    state_d  = ST_DONE;
                    own_d    = 1'b0;
                    done_d   = 1'b1;
                    cycles_d = status[31:CYC_LSB];
                end else if (cnt_zero) begin
                    state_d    = ST_ERR;
                    own_d      = 1'b0;
                    error_d    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            slot_q      <= '0;
            own_q       <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
            cycles_q    <= '0;
            ctrl_low_q  <= '0;
            ctrl_high_q <= '0;
            dina_low_q  <= '0;
            dina_high_q <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            own_q       <= own_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
            cycles_q    <= cycles_d;
            ctrl_low_q  <= ctrl_low_d;
            ctrl_high_q <= ctrl_high_d;
            dina_low_q  <= dina_low_d;
            dina_high_q <= dina_high_d;
        end
    end

    assign control_low_word   = own_q ? ctrl_low_q  : host_ctrl_low;
    assign control_high_word  = own_q ? ctrl_high_q : host_ctrl_high;
    assign dina_ext_low_word  = own_q ? dina_low_q  : host_dina_low;
    assign dina_ext_high_word = own_q ? dina_high_q : host_dina_high;

    assign instr_ready = ready_q;
    assign busy        = !is_host_state(state_q);
    assign done        = done_q;
    assign error       = error_q;
    assign err_code    = err_code_q;
    assign cycles      = cycles_q;

endmodule

// File: tb/tb_isa_program_sequencer.sv
// Directed bench for isa_program_sequencer with a shortened timeout.
module tb_isa_program_sequencer;

    logic        clk = 1'b0;
    logic        rst, go, instr_valid, instr_ready, instr_last;
    logic [43:0] instr_data;
    logic [31:0] host_ctrl_low, host_ctrl_high, host_dina_low, host_dina_high, status;
    logic [31:0] control_low_word, control_high_word, dina_ext_low_word, dina_ext_high_word;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [29:0] cycles;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    isa_program_sequencer #(.TIMEOUT_CYCLES(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .go                 (go),
        .instr_valid        (instr_valid),
        .instr_ready        (instr_ready),
        .instr_data         (instr_data),
        .instr_last         (instr_last),
        .host_ctrl_low      (host_ctrl_low),
        .host_ctrl_high     (host_ctrl_high),
        .host_dina_low      (host_dina_low),
        .host_dina_high     (host_dina_high),
        .status             (status),
        .control_low_word   (control_low_word),
        .control_high_word  (control_high_word),
        .dina_ext_low_word  (dina_ext_low_word),
        .dina_ext_high_word (dina_ext_high_word),
        .busy               (busy),
        .done               (done),
        .error              (error),
        .err_code           (err_code),
        .cycles             (cycles)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue go from an idle/done/error state and advance to the first LOAD cycle.
    task automatic start_program();
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("crst_high", control_high_word, 32'h1);
            check("crst_busy", busy, 1'b1);
            tick();
        end
        check("load_ready", instr_ready, 1'b1);
        check("load_high", control_high_word, 32'h0);
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; instr_valid = 1'b0; instr_last = 1'b0; instr_data = '0;
        host_ctrl_low = 32'h0; host_ctrl_high = 32'h0000_1230;
        host_dina_low = 32'h5555_AAAA; host_dina_high = 32'h0000_0777; status = 32'h0;
        tick(); tick();
        rst = 1'b0;

        // Reset state and idle passthrough
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_ready", instr_ready, 1'b0);
        check("rst_errcode", err_code, 2'd0);
        check("rst_cycles", cycles, 30'd0);
        host_ctrl_low = 32'h2001_0005;
        #1;
        check("idle_pass_low", control_low_word, 32'h2001_0005);
        check("idle_pass_high", control_high_word, 32'h0000_1230);
        check("idle_pass_dina_lo", dina_ext_low_word, 32'h5555_AAAA);
        check("idle_pass_dina_hi", dina_ext_high_word, 32'h0000_0777);

        // Three-instruction program, done after start
        start_program();
        instr_valid = 1'b1; instr_data = 44'hABC_1234_5678;
        tick();
        check("wr0_low", control_low_word, 32'h0003_0000);
        check("wr0_dhi", dina_ext_high_word, 32'h0000_0ABC);
        check("wr0_dlo", dina_ext_low_word, 32'h1234_5678);
        tick();
        check("wr1_low", control_low_word, 32'h0003_0001);
        instr_last = 1'b1;
        tick();
        check("wr2_low", control_low_word, 32'h0003_0002);
        check("wr2_high", control_high_word, 32'h0);
        check("wr2_ready", instr_ready, 1'b0);
        instr_valid = 1'b0; instr_last = 1'b0;
        tick();
        check("start_high", control_high_word, 32'h2);
        check("start_low", control_low_word, 32'h0);
        tick();
        check("start_single", control_high_word, 32'h0);
        for (int i = 0; i < 8; i++) tick();
        check("wait_busy", busy, 1'b1);
        status = 32'h0000_0141;
        tick();
        status = 32'h0;
        check("done_flag", done, 1'b1);
        check("done_busy", busy, 1'b0);
        check("done_cycles", cycles, 30'h50);
        check("done_error", error, 1'b0);
        check("done_pass_low", control_low_word, 32'h2001_0005);

        // Sixteen instructions without last: overflow
        start_program();
        check("restart_done_clr", done, 1'b0);
        check("restart_cyc_clr", cycles, 30'd0);
        instr_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            instr_data = {12'h100 + 12'(i), 32'hCAFE_0000 + 32'(i)};
            tick();
            check("ovf_low", control_low_word, 32'h0003_0000 + 32'(i));
            check("ovf_dlo", dina_ext_low_word, 32'hCAFE_0000 + 32'(i));
            check("ovf_dhi", dina_ext_high_word, 32'h100 + 32'(i));
            check("ovf_error", error, (i == 15) ? 1'b1 : 1'b0);
            check("ovf_ready", instr_ready, (i == 15) ? 1'b0 : 1'b1);
        end
        instr_valid = 1'b0;
        check("ovf_errcode", err_code, 2'd1);
        check("ovf_busy", busy, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ovf_no_start", control_high_word, 32'h0000_1230);
            check("ovf_err_hold", error, 1'b1);
        end

        // Timeout: status never signals done
        start_program();
        check("restart_err_clr", error, 1'b0);
        instr_valid = 1'b1; instr_last = 1'b1; instr_data = 44'h000_0000_0001;
        tick();
        instr_valid = 1'b0; instr_last = 1'b0;
        check("to_wr_low", control_low_word, 32'h0003_0000);
        tick();
        check("to_start", control_high_word, 32'h2);
        tick(); tick();
        for (int i = 0; i < 32; i++) begin
            check("to_wait_err", error, 1'b0);
            check("to_wait_busy", busy, 1'b1);
            tick();
        end
        check("to_error", error, 1'b1);
        check("to_errcode", err_code, 2'd2);
        check("to_busy", busy, 1'b0);

        // Done arriving on the final count cycle wins over timeout
        start_program();
        instr_valid = 1'b1; instr_last = 1'b1; instr_data = 44'h000_0000_0002;
        tick();
        instr_valid = 1'b0; instr_last = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < 31; i++) tick();
        status = 32'h0000_0009;
        tick();
        status = 32'h0;
        check("late_done", done, 1'b1);
        check("late_error", error, 1'b0);
        check("late_cycles", cycles, 30'd2);

        // Reset in the middle of LOAD, then restart at slot 0
        start_program();
        instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            instr_data = 44'(i);
            tick();
        end
        check("mid_wr4", control_low_word, 32'h0003_0004);
        rst = 1'b1;
        tick();
        rst = 1'b0; instr_valid = 1'b0;
        check("mid_rst_low", control_low_word, 32'h2001_0005);
        check("mid_rst_ready", instr_ready, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        start_program();
        instr_valid = 1'b1; instr_last = 1'b1; instr_data = 44'h123_0000_0042;
        tick();
        instr_valid = 1'b0; instr_last = 1'b0;
        check("restart_slot0", control_low_word, 32'h0003_0000);
        check("restart_dlo", dina_ext_low_word, 32'h0000_0042);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
